// File: rtl/alu_issue_pkg.sv
// Shared definitions for the ALU issue stage: op encodings, FLAGS bit positions,
// FLAGS reset value and the per-op flag commit masks.
package alu_issue_pkg;

  localparam int DATA_W          = 16;
  localparam int MC_ALUOp_t_BITS = 3;

  typedef enum logic [MC_ALUOp_t_BITS-1:0] {
    ALUOp_SELA = 3'd0,
    ALUOp_SELB = 3'd1,
    ALUOp_ADD  = 3'd2,
    ALUOp_ADC  = 3'd3,
    ALUOp_AND  = 3'd4
  } MC_ALUOp_t;

  localparam int CF_IDX = 0;
  localparam int PF_IDX = 2;
  localparam int AF_IDX = 4;
  localparam int ZF_IDX = 6;
  localparam int SF_IDX = 7;
  localparam int OF_IDX = 11;

  localparam logic [DATA_W-1:0] FLAGS_RESET      = 16'h0002;
  localparam logic [DATA_W-1:0] FLAGS_MASK_ARITH = 16'h08D5;
  localparam logic [DATA_W-1:0] FLAGS_MASK_LOGIC = 16'h08C5;
  localparam logic [DATA_W-1:0] FLAGS_MASK_NONE  = 16'h0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } issue_state_t;

  typedef struct packed {
    logic [MC_ALUOp_t_BITS-1:0] op;
    logic [DATA_W-1:0]          a;
    logic [DATA_W-1:0]          b;
    logic                       is_8_bit;
    logic                       update_flags;
  } issue_req_t;

  function automatic logic op_known(input logic [MC_ALUOp_t_BITS-1:0] op);
    case (op)
      ALUOp_SELA, ALUOp_SELB, ALUOp_ADD, ALUOp_ADC, ALUOp_AND: return 1'b1;
      default:                                                 return 1'b0;
    endcase
  endfunction

  // Unrecognised ops fall into the default arm and therefore never touch FLAGS.
  function automatic logic [DATA_W-1:0] flag_mask(input logic [MC_ALUOp_t_BITS-1:0] op);
    case (op)
      ALUOp_ADD, ALUOp_ADC: return FLAGS_MASK_ARITH;
      ALUOp_AND:            return FLAGS_MASK_LOGIC;
      default:              return FLAGS_MASK_NONE;
    endcase
  endfunction

endpackage

// File: rtl/alu_issue_flags_reg.sv
// Architectural FLAGS register: masked merge of ALU flags on commit, external load
// with priority over the commit, bit 1 always reads as 1.
module alu_issue_flags_reg
  import alu_issue_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              i_commit,
  input  logic [DATA_W-1:0] i_mask,
  input  logic [DATA_W-1:0] i_alu_flags,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_load_val,
  output logic [DATA_W-1:0] o_flags,
  output logic [DATA_W-1:0] o_flags_next
);

  logic [DATA_W-1:0] r_flags;
  logic [DATA_W-1:0] w_merge;

  // A load replaces the whole register, so a coincident commit is dropped entirely.
  always_comb begin
    w_merge = r_flags;
    if (i_load) begin
      w_merge = i_load_val;
    end else if (i_commit) begin
      w_merge = (r_flags & ~i_mask) | (i_alu_flags & i_mask);
    end
    w_merge[1] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_flags <= FLAGS_RESET;
    end else begin
      r_flags <= w_merge;
    end
  end

  assign o_flags      = r_flags;
  assign o_flags_next = w_merge;

endmodule

// File: rtl/alu_issue.sv
// Issue stage for an external combinational ALU: one op in flight through
// IDLE -> EXEC -> RESP, with architectural FLAGS held in alu_issue_flags_reg.
module alu_issue
  import alu_issue_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [MC_ALUOp_t_BITS-1:0] req_op,
  input  logic [DATA_W-1:0]          req_a,
  input  logic [DATA_W-1:0]          req_b,
  input  logic                       req_is_8_bit,
  input  logic                       req_update_flags,
  output logic [DATA_W-1:0]          alu_a,
  output logic [DATA_W-1:0]          alu_b,
  output logic [MC_ALUOp_t_BITS-1:0] alu_op,
  output logic                       alu_is_8_bit,
  output logic [DATA_W-1:0]          alu_flags_in,
  input  logic [DATA_W-1:0]          alu_out,
  input  logic [DATA_W-1:0]          alu_flags_out,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [DATA_W-1:0]          rsp_result,
  output logic [DATA_W-1:0]          rsp_flags,
  input  logic                       flags_load,
  input  logic [DATA_W-1:0]          flags_load_val,
  output logic [DATA_W-1:0]          flags
);

  issue_state_t      r_state;
  issue_state_t      w_state_next;
  issue_req_t        r_req;
  logic              w_accept;
  logic              w_in_exec;
  logic              w_known;
  logic              w_commit;
  logic [DATA_W-1:0] w_mask;
  logic [DATA_W-1:0] w_alu_flags;
  logic [DATA_W-1:0] w_result;
  logic [DATA_W-1:0] w_flags_next;
  logic [DATA_W-1:0] r_rsp_result;
  logic [DATA_W-1:0] r_rsp_flags;

  // Ready is held low during reset so nothing is accepted in the reset cycle.
  assign req_ready = ~reset & ((r_state == ST_IDLE) | ((r_state == ST_RESP) & rsp_ready));
  assign w_accept  = req_valid & req_ready;
  assign w_in_exec = (r_state == ST_EXEC);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) w_state_next = ST_EXEC;
      end
      ST_EXEC: begin
        w_state_next = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) w_state_next = w_accept ? ST_EXEC : ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Accept -> EXEC boundary: request fields are registered and drive the ALU.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_req.op           <= req_op;
      r_req.a            <= req_a;
      r_req.b            <= req_b;
      r_req.is_8_bit     <= req_is_8_bit;
      r_req.update_flags <= req_update_flags;
    end
  end

  assign w_known      = op_known(r_req.op);
  assign w_mask       = flag_mask(r_req.op);
  assign alu_a        = r_req.a;
  assign alu_b        = r_req.b;
  assign alu_op       = w_known ? r_req.op : ALUOp_SELA;
  assign alu_is_8_bit = r_req.is_8_bit;
  assign alu_flags_in = flags;

  // Logical AND always clears OF regardless of what the ALU reports.
  always_comb begin
    w_alu_flags = alu_flags_out;
    if (r_req.op == ALUOp_AND) w_alu_flags[OF_IDX] = 1'b0;
    w_result = '0;
    if (w_known) w_result = r_req.is_8_bit ? {8'h00, alu_out[7:0]} : alu_out;
  end

  assign w_commit = w_in_exec & r_req.update_flags;

  alu_issue_flags_reg u_flags_reg (
    .clk          (clk),
    .reset        (reset),
    .i_commit     (w_commit),
    .i_mask       (w_mask),
    .i_alu_flags  (w_alu_flags),
    .i_load       (flags_load),
    .i_load_val   (flags_load_val),
    .o_flags      (flags),
    .o_flags_next (w_flags_next)
  );

  // EXEC -> RESP boundary: result and post-commit FLAGS are frozen for the response.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rsp_result <= '0;
      r_rsp_flags  <= FLAGS_RESET;
    end else if (w_in_exec) begin
      r_rsp_result <= w_result;
      r_rsp_flags  <= w_flags_next;
    end
  end

  assign rsp_valid  = (r_state == ST_RESP);
  assign rsp_result = r_rsp_result;
  assign rsp_flags  = r_rsp_flags;

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: a stand-in combinational ALU plus a transaction-level
// FLAGS/result model, directed scenarios followed by randomized operations.
module tb_alu_issue;
  import alu_issue_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic        req_is_8_bit;
  logic        req_update_flags;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [2:0]  alu_op;
  logic        alu_is_8_bit;
  logic [15:0] alu_flags_in;
  logic [15:0] alu_out;
  logic [15:0] alu_flags_out;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_result;
  logic [15:0] rsp_flags;
  logic        flags_load;
  logic [15:0] flags_load_val;
  logic [15:0] flags;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] m_flags;
  logic [31:0] w_alu;

  always #5 clk = ~clk;

  alu_issue dut (
    .clk              (clk),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_op           (req_op),
    .req_a            (req_a),
    .req_b            (req_b),
    .req_is_8_bit     (req_is_8_bit),
    .req_update_flags (req_update_flags),
    .alu_a            (alu_a),
    .alu_b            (alu_b),
    .alu_op           (alu_op),
    .alu_is_8_bit     (alu_is_8_bit),
    .alu_flags_in     (alu_flags_in),
    .alu_out          (alu_out),
    .alu_flags_out    (alu_flags_out),
    .rsp_valid        (rsp_valid),
    .rsp_ready        (rsp_ready),
    .rsp_result       (rsp_result),
    .rsp_flags        (rsp_flags),
    .flags_load       (flags_load),
    .flags_load_val   (flags_load_val),
    .flags            (flags)
  );

  // x86-style semantics; returns {flags, result}
  function automatic logic [31:0] alu_eval(input logic [2:0] op, input logic [15:0] a,
                                           input logic [15:0] b, input logic is8, input logic cin);
    int unsigned w, msk, ua, ub, c, sum;
    logic [15:0] r, f;
    logic sa, sb, sr;
    w   = is8 ? 8 : 16;
    msk = is8 ? 32'hFF : 32'hFFFF;
    ua  = 32'(a) & msk;
    ub  = 32'(b) & msk;
    c   = (op == ALUOp_ADC) ? 32'(cin) : 32'd0;
    f   = '0;
    r   = '0;
    case (op)
      ALUOp_ADD, ALUOp_ADC: begin
        sum       = ua + ub + c;
        r         = 16'(sum & msk);
        f[CF_IDX] = ((sum >> w) & 1) != 0;
        f[AF_IDX] = ((ua & 15) + (ub & 15) + c) > 15;
        sa        = ((ua >> (w - 1)) & 1) != 0;
        sb        = ((ub >> (w - 1)) & 1) != 0;
        sr        = ((sum >> (w - 1)) & 1) != 0;
        f[OF_IDX] = (sa == sb) && (sr != sa);
      end
      ALUOp_AND:  r = 16'(ua & ub);
      ALUOp_SELB: r = b;
      default:    r = a;
    endcase
    f[PF_IDX] = ~^r[7:0];
    f[ZF_IDX] = (32'(r) & msk) == 0;
    f[SF_IDX] = ((32'(r) >> (w - 1)) & 1) != 0;
    return {f, r};
  endfunction

  // Stand-in ALU: junk in the upper byte of byte results and in flag bits the
  // issue stage must ignore (including AF and OF for AND).
  always_comb begin
    w_alu         = alu_eval(alu_op, alu_a, alu_b, alu_is_8_bit, alu_flags_in[CF_IDX]);
    alu_out       = alu_is_8_bit ? {8'hA5, w_alu[7:0]} : w_alu[15:0];
    alu_flags_out = w_alu[31:16] | 16'hF72A | ((alu_op == ALUOp_AND) ? 16'h0810 : 16'h0000);
  end

  function automatic logic [15:0] ref_mask(input logic [2:0] op);
    logic [15:0] m;
    m = '0;
    if (op == ALUOp_ADD || op == ALUOp_ADC)
      m = (16'(1) << CF_IDX) | (16'(1) << PF_IDX) | (16'(1) << AF_IDX) |
          (16'(1) << ZF_IDX) | (16'(1) << SF_IDX) | (16'(1) << OF_IDX);
    else if (op == ALUOp_AND)
      m = (16'(1) << CF_IDX) | (16'(1) << PF_IDX) |
          (16'(1) << ZF_IDX) | (16'(1) << SF_IDX) | (16'(1) << OF_IDX);
    return m;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    req_valid  = 1'b0;
    flags_load = 1'b0;
    tick();
    reset   = 1'b0;
    m_flags = 16'h0002;
  endtask

  task automatic issue(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic is8, input logic upd);
    req_valid        = 1'b1;
    req_op           = op;
    req_a            = a;
    req_b            = b;
    req_is_8_bit     = is8;
    req_update_flags = upd;
  endtask

  // One op from IDLE back to IDLE. load_mode: 0 none, 1 load in EXEC, 2 load while stalled.
  task automatic run_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic is8, input logic upd, input int load_mode,
                        input logic [15:0] lval, input int stall);
    logic [31:0] t;
    logic [15:0] exp_res, exp_rflags;
    logic        known;
    known = (op <= 3'd4);
    issue(op, a, b, is8, upd);
    rsp_ready = 1'b0;
    #1 chk("idle_ready", 16'(req_ready), 16'd1);
    tick();
    req_valid      = 1'b0;
    flags_load     = (load_mode == 1);
    flags_load_val = lval;
    rsp_ready      = (stall == 0);
    #1;
    chk("exec_ready", 16'(req_ready), 16'd0);
    chk("exec_valid", 16'(rsp_valid), 16'd0);
    chk("exec_alu_op", 16'(alu_op), known ? 16'(op) : 16'(ALUOp_SELA));
    chk("exec_alu_a", alu_a, a);
    chk("exec_alu_b", alu_b, b);
    chk("exec_flags_in", alu_flags_in, m_flags);
    t       = alu_eval(known ? op : ALUOp_SELA, a, b, is8, m_flags[CF_IDX]);
    exp_res = known ? (is8 ? {8'h00, t[7:0]} : t[15:0]) : 16'h0000;
    if (load_mode == 1)
      m_flags = lval | 16'h0002;
    else if (upd)
      m_flags = (m_flags & ~ref_mask(op)) | (t[31:16] & ref_mask(op)) | 16'h0002;
    exp_rflags = m_flags;
    tick();
    flags_load = 1'b0;
    chk("resp_valid", 16'(rsp_valid), 16'd1);
    chk("resp_result", rsp_result, exp_res);
    chk("resp_flags", rsp_flags, exp_rflags);
    chk("arch_flags", flags, m_flags);
    for (int i = 0; i < stall; i++) begin
      req_valid  = 1'b1;
      flags_load = (load_mode == 2) && (i == 0);
      #1 chk("stall_ready", 16'(req_ready), 16'd0);
      tick();
      flags_load = 1'b0;
      if (load_mode == 2 && i == 0) m_flags = lval | 16'h0002;
      chk("stall_valid", 16'(rsp_valid), 16'd1);
      chk("stall_result", rsp_result, exp_res);
      chk("stall_rflags", rsp_flags, exp_rflags);
      chk("stall_flags", flags, m_flags);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    chk("back_idle", 16'(rsp_valid), 16'd0);
  endtask

  initial begin
    reset            = 1'b1;
    req_valid        = 1'b0;
    req_op           = '0;
    req_a            = '0;
    req_b            = '0;
    req_is_8_bit     = 1'b0;
    req_update_flags = 1'b0;
    rsp_ready        = 1'b0;
    flags_load       = 1'b0;
    flags_load_val   = '0;
    m_flags          = 16'h0002;

    // Reset state
    #1 chk("ready_in_reset", 16'(req_ready), 16'd0);
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("rst_rsp_valid", 16'(rsp_valid), 16'd0);
    chk("rst_rsp_result", rsp_result, 16'h0000);
    chk("rst_rsp_flags", rsp_flags, 16'h0002);
    chk("rst_flags", flags, 16'h0002);
    chk("rst_ready", 16'(req_ready), 16'd1);

    // 16-bit ADD 0xFFFF+1, then ADC issued in the response handshake cycle
    issue(ALUOp_ADD, 16'hFFFF, 16'h0001, 1'b0, 1'b1);
    tick();
    req_valid = 1'b0;
    chk("add_n1_valid", 16'(rsp_valid), 16'd0);
    tick();
    chk("add_n2_valid", 16'(rsp_valid), 16'd1);
    chk("add_result", rsp_result, 16'h0000);
    chk("add_rsp_flags", rsp_flags, 16'h0057);
    chk("add_flags", flags, 16'h0057);
    issue(ALUOp_ADC, 16'h0001, 16'h0001, 1'b0, 1'b1);
    rsp_ready = 1'b1;
    #1 chk("b2b_ready", 16'(req_ready), 16'd1);
    tick();
    req_valid = 1'b0;
    chk("b2b_exec_valid", 16'(rsp_valid), 16'd0);
    tick();
    chk("adc_valid", 16'(rsp_valid), 16'd1);
    chk("adc_result", rsp_result, 16'h0003);
    chk("adc_cf", 16'(rsp_flags[CF_IDX]), 16'd0);
    chk("adc_rsp_flags", rsp_flags, 16'h0006);
    tick();
    chk("adc_idle", 16'(rsp_valid), 16'd0);

    // 8-bit ADD 0x7F+1, then held response with a pending request
    do_reset();
    issue(ALUOp_ADD, 16'h007F, 16'h0001, 1'b1, 1'b1);
    rsp_ready = 1'b0;
    tick();
    issue(ALUOp_SELB, 16'h1234, 16'h5678, 1'b0, 1'b1);
    tick();
    chk("b8_result", rsp_result, 16'h0080);
    chk("b8_rsp_flags", rsp_flags, 16'h0892);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("hold_ready", 16'(req_ready), 16'd0);
      chk("hold_valid", 16'(rsp_valid), 16'd1);
      chk("hold_result", rsp_result, 16'h0080);
      chk("hold_rflags", rsp_flags, 16'h0892);
      tick();
    end
    rsp_ready = 1'b1;
    #1 chk("release_ready", 16'(req_ready), 16'd1);
    tick();
    req_valid = 1'b0;
    chk("second_exec", 16'(rsp_valid), 16'd0);
    tick();
    chk("selb_result", rsp_result, 16'h5678);
    chk("selb_rsp_flags", rsp_flags, 16'h0892);
    tick();
    m_flags = 16'h0892;

    // flags_load coincident with the EXEC commit wins
    issue(ALUOp_ADD, 16'hFFFF, 16'h0001, 1'b0, 1'b1);
    tick();
    req_valid      = 1'b0;
    flags_load     = 1'b1;
    flags_load_val = 16'h0000;
    tick();
    flags_load = 1'b0;
    chk("load_win_flags", flags, 16'h0002);
    chk("load_win_rflags", rsp_flags, 16'h0002);
    chk("load_win_result", rsp_result, 16'h0000);
    tick();

    // Reset during EXEC discards the op, and overrides a coincident load
    flags_load     = 1'b1;
    flags_load_val = 16'hFFFF;
    tick();
    flags_load = 1'b0;
    chk("load_idle", flags, 16'hFFFF);
    issue(ALUOp_ADD, 16'h1234, 16'h1111, 1'b0, 1'b1);
    tick();
    req_valid      = 1'b0;
    reset          = 1'b1;
    flags_load     = 1'b1;
    flags_load_val = 16'h0800;
    #1 chk("rst_exec_ready", 16'(req_ready), 16'd0);
    tick();
    reset      = 1'b0;
    flags_load = 1'b0;
    #1;
    chk("rst_exec_valid", 16'(rsp_valid), 16'd0);
    chk("rst_exec_flags", flags, 16'h0002);
    chk("rst_exec_result", rsp_result, 16'h0000);
    chk("rst_exec_ready1", 16'(req_ready), 16'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("no_ghost_rsp", 16'(rsp_valid), 16'd0);
    end
    m_flags = 16'h0002;

    // Unrecognised op and byte select
    run_op(3'd6, 16'hBEEF, 16'h0001, 1'b0, 1'b1, 0, 16'h0000, 0);
    run_op(ALUOp_SELA, 16'h1234, 16'h0000, 1'b1, 1'b1, 0, 16'h0000, 1);
    run_op(ALUOp_AND, 16'h8F0F, 16'h80F1, 1'b0, 1'b1, 0, 16'h0000, 0);

    // Randomized operations against the model
    for (int n = 0; n < 150; n++) begin
      logic [2:0]  op;
      int          lm, st;
      op = 3'($urandom_range(0, 7));
      st = $urandom_range(0, 3);
      lm = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
      if (lm == 2 && st == 0) lm = 0;
      run_op(op, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
             lm, 16'($urandom), st);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
